// File: rtl/pipefft_dly_line.sv
// Programmable delay line for the pipelined FFT: an enabled shift register of
// length D (1..2^AW) built on a circular micro-RAM with a registered output.
module pipefft_dly_line #(
    parameter int WIDTH = 68,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [AW:0]      dly,
    input  logic             en,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);

    localparam int N = 1 << AW;
    localparam logic [AW:0] DEPTH_MAX = (AW + 1)'(N);

    logic [WIDTH-1:0] mem [N];
    logic [AW-1:0]    wptr;
    logic [AW:0]      dLat;
    logic [AW:0]      fill;
    logic [AW:0]      dSel;
    logic [AW:0]      fillInc;
    logic             reachFull;
    logic [AW-1:0]    rdAddr;
    logic [WIDTH-1:0] rdData;
    logic             clearLine;

    assign clearLine = rst | flush;

    // Requested delay is clamped into the range the storage can support.
    always_comb begin
        dSel = dly;
        if (dly == '0) begin
            dSel = (AW + 1)'(1);
        end else if (dly > DEPTH_MAX) begin
            dSel = DEPTH_MAX;
        end
    end

    // Output register holds stage D, so RAM supplies the sample D-1 enables old.
    // For D=N the low AW bits of dLat are zero and the address wraps to wptr+1.
    assign rdAddr    = wptr - dLat[AW-1:0] + AW'(1);
    assign rdData    = mem[rdAddr];
    assign fillInc   = fill + (AW + 1)'(1);
    assign reachFull = (fillInc >= dLat);

    always_ff @(posedge clk) begin
        if (clearLine) begin
            wptr      <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            dLat      <= dSel;
        end else if (en) begin
            wptr      <= wptr + AW'(1);
            fill      <= reachFull ? dLat : fillInc;
            out_valid <= out_valid | reachFull;
            if (!reachFull) begin
                out_data <= '0;
            end else if (dLat == (AW + 1)'(1)) begin
                out_data <= in_data;
            end else begin
                out_data <= rdData;
            end
        end
    end

    // Storage array carries no reset; fill gating keeps stale words hidden.
    always_ff @(posedge clk) begin
        if (en && !clearLine) begin
            mem[wptr] <= in_data;
        end
    end

endmodule
